// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS instruction-fetch front end.
//   XLEN_DEF      default PC / instruction width
//   RESET_PC_DEF  default PC loaded on reset
//   fetch_state_e fetch FSM states (IDLE / RUN / ERR)
//   NOP_INSTR     instruction word presented to decode when nothing is valid
//   PC_INC        byte increment between sequential instructions
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          PC_INC       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_e;

  // A redirect target is usable only if it is word aligned.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit_if
// Bundles the instruction-memory request/response channel and the decode
// valid/ready channel of the fetch unit.
//   master : the fetch unit (drives imem requests and decode entries)
//   slave  : the memory / decode side
// Signals:
//   imem_req_valid/ready/addr  request handshake, byte address of the word
//   imem_rsp_valid/data        in-order response, no backpressure
//   id_valid/ready             decode handshake
//   id_instr/id_pc/id_pc_plus4 head entry of the fetch queue
// ---------------------------------------------------------------------------
interface mips_fetch_unit_if #(
  parameter int XLEN = mips_pkg::XLEN_DEF
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_instr, id_pc, id_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_instr, id_pc, id_pc_plus4,
    output id_ready
  );

endinterface

// File: rtl/mips_sync_fifo.sv
// ---------------------------------------------------------------------------
// mips_sync_fifo
// Single-clock first-in first-out buffer with synchronous flush.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      empties the buffer this cycle (push/pop ignored)
//   push/wdata write request and data
//   pop        read request; rdata shows the oldest entry
//   count      number of stored entries
//   empty      count == 0
// A push on a full buffer is accepted only if a pop happens the same cycle.
// ---------------------------------------------------------------------------
module mips_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; count/empty guard
  // every read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-fetch front end: owns the PC, issues requests to a
// latency-tolerant instruction memory, buffers returned words in an in-order
// fetch queue and hands them to decode over a valid/ready handshake.
// Branch redirects flush the queue and discard responses still in flight.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   fetch_en        low holds the unit in IDLE (no new requests)
//   redirect_valid  taken branch/jump from MEM stage
//   redirect_pc     redirect target (must be word aligned)
//   bus             mips_fetch_unit_if.master: imem request/response and
//                   decode handshake
//   misalign_err    sticky; set by a misaligned redirect, cleared by rst
//   perf_fetch_cnt  saturating count of decode pops     (optional)
//   perf_flush_cnt  saturating count of aligned redirects (optional)
//
// Optional feature: define MIPS_FETCH_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              FQ_DEPTH = 4,
  parameter int              CNT_W    = $clog2(FQ_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  mips_fetch_unit_if.master bus,
  output logic             misalign_err
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;

  logic            redirect_ok;
  logic            redirect_bad;
  logic            has_credit;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_accept;
  logic            rsp_push;
  logic            q_pop;

  logic [2*XLEN-1:0] iq_rdata;
  logic [CNT_W-1:0]  q_count;
  logic              q_empty;
  logic [XLEN-1:0]   tag_pc;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_empty;
  logic [XLEN-1:0]   head_pc;

  assign redirect_ok  = redirect_valid &&  is_word_aligned(redirect_pc[1:0]);
  assign redirect_bad = redirect_valid && !is_word_aligned(redirect_pc[1:0]);

  // Queue entries plus in-flight requests may never exceed the queue size,
  // so every response finds a free slot and memory needs no backpressure.
  assign has_credit = ({1'b0, q_count} + {1'b0, outstanding}) < (CNT_W+1)'(FQ_DEPTH);

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (state_q)
      IDLE: if (fetch_en) state_d = RUN;
      RUN: begin
        if (!fetch_en) state_d = IDLE;
        req_valid = !redirect_valid && has_credit;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (redirect_bad) state_d = ERR;
  end

  assign misalign_err = (state_q == ERR);

  // -------------------------------------------------------------------------
  // Request / response bookkeeping
  // -------------------------------------------------------------------------
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign rsp_accept = bus.imem_rsp_valid && (outstanding != '0);
  // A response landing in a redirect cycle is stale and is discarded too.
  assign rsp_push   = rsp_accept && (drop_cnt == '0) && !redirect_ok && !tag_empty;
  assign q_pop      = !q_empty && bus.id_ready && !redirect_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_ok) begin
      pc_q <= redirect_pc;
    end else if (req_fire) begin
      pc_q <= pc_q + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) outstanding <= '0;
    else     outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_accept);
  end

  // After a redirect every request still in flight belongs to the old path,
  // so the drop set becomes the whole remaining in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_ok) begin
      drop_cnt <= outstanding - CNT_W'(rsp_accept);
    end else if (rsp_accept && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // PC-tag FIFO: PCs of issued requests whose words will be kept. Dropped
  // responses never pop it, so it is flushed on redirect along with the queue.
  // -------------------------------------------------------------------------
  mips_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_ok),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (rsp_push),
    .rdata (tag_pc),
    .count (tag_count),
    .empty (tag_empty)
  );

  // -------------------------------------------------------------------------
  // Instruction queue: {instr, pc}
  // -------------------------------------------------------------------------
  mips_sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_instr_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_ok),
    .push  (rsp_push),
    .wdata ({bus.imem_rsp_data, tag_pc}),
    .pop   (q_pop),
    .rdata (iq_rdata),
    .count (q_count),
    .empty (q_empty)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;

  assign head_pc         = q_empty ? '0 : iq_rdata[XLEN-1:0];
  assign bus.id_valid    = !q_empty;
  assign bus.id_instr    = q_empty ? XLEN'(NOP_INSTR) : iq_rdata[2*XLEN-1:XLEN];
  assign bus.id_pc       = head_pc;
  assign bus.id_pc_plus4 = q_empty ? '0 : head_pc + XLEN'(PC_INC);

`ifdef MIPS_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (q_pop && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_ok && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  // Each in-flight request is either marked for dropping or has a tag.
  a_inflight_accounting: assert property (
    @(posedge clk) disable iff (rst)
    ({1'b0, drop_cnt} + {1'b0, tag_count}) == {1'b0, outstanding}
  );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
// Self-checking bench for mips_fetch_unit. A small in-order memory model with
// selectable latency answers requests with instr_of(addr). A vector table
// covers sequential fetch and fetch_en gating; hand-written sequences cover
// decode stall, redirect with stale responses, misaligned redirect, PC wrap
// and (with MIPS_FETCH_PERF_EN) the performance counters.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_err;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int lat         = 1;
  int n_fire      = 0;

  logic [3:0]  pv = '0;
  logic [31:0] pa [4];

  mips_fetch_unit_if #(.XLEN(32)) bus ();

  mips_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .misalign_err   (misalign_err)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // In-order memory: a request accepted at one edge is answered `lat`
  // cycles later, one response per cycle.
  assign bus.imem_req_ready = 1'b1;
  assign bus.imem_rsp_valid = pv[lat-1];
  assign bus.imem_rsp_data  = instr_of(pa[lat-1]);

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], bus.imem_req_valid & bus.imem_req_ready};
      pa[0] <= bus.imem_req_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
      if (bus.imem_req_valid && bus.imem_req_ready) n_fire <= n_fire + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int lat_v);
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.id_ready   = 1'b0;
    lat            = lat_v;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        fetch_en;
    logic        id_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        id_valid;
    logic [31:0] id_pc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  base;
    int  pops;
    logic found;

    // Sequential fetch with a 1-cycle memory, then fetch_en dropped and
    // re-raised: the queue drains, the PC is kept.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h14};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h18};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h1C, 1'b0, 32'h00};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h1C, 1'b0, 32'h00};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};

    // ---- reset state ----
    do_reset(1);
    #1;
    check("reset req_valid",   32'(bus.imem_req_valid), 32'd0);
    check("reset req_addr",    bus.imem_req_addr,       32'h0);
    check("reset id_valid",    32'(bus.id_valid),       32'd0);
    check("reset id_instr",    bus.id_instr,            32'h0);
    check("reset id_pc",       bus.id_pc,               32'h0);
    check("reset id_pc_plus4", bus.id_pc_plus4,         32'h0);
    check("reset misalign",    32'(misalign_err),       32'd0);

    // ---- table: sequential fetch ----
    for (int i = 0; i < NV; i++) begin
      fetch_en     = vecs[i].fetch_en;
      bus.id_ready = vecs[i].id_ready;
      #1;
      check($sformatf("v%0d req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].req_valid));
      check($sformatf("v%0d req_addr", i),  bus.imem_req_addr,       vecs[i].req_addr);
      check($sformatf("v%0d id_valid", i),  32'(bus.id_valid),       32'(vecs[i].id_valid));
      check($sformatf("v%0d id_pc", i),     bus.id_pc,               vecs[i].id_pc);
      check($sformatf("v%0d id_instr", i),  bus.id_instr,
            vecs[i].id_valid ? instr_of(vecs[i].id_pc) : 32'h0);
      check($sformatf("v%0d id_pc_plus4", i), bus.id_pc_plus4,
            vecs[i].id_valid ? vecs[i].id_pc + 32'd4 : 32'h0);
      tick();
    end

    // ---- decode stall: credit limits requests to the queue depth ----
    do_reset(1);
    fetch_en     = 1'b1;
    bus.id_ready = 1'b0;
    base = n_fire;
    repeat (12) tick();
    #1;
    check("stall request count", 32'(n_fire - base), 32'd4);
    check("stall req_valid",     32'(bus.imem_req_valid), 32'd0);
    bus.id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("drain%0d id_valid", k), 32'(bus.id_valid), 32'd1);
      check($sformatf("drain%0d id_pc", k),    bus.id_pc,         32'(4 * k));
      check($sformatf("drain%0d id_instr", k), bus.id_instr,      instr_of(32'(4 * k)));
      tick();
    end

    // ---- redirect with 3 responses in flight (3-cycle memory) ----
    do_reset(3);
    fetch_en     = 1'b1;
    bus.id_ready = 1'b1;
    base = n_fire;
    repeat (4) tick();
    #1;
    check("redir in-flight",  32'(n_fire - base), 32'd3);
    check("redir pre id_valid", 32'(bus.id_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("redir req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.id_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("redir id_valid seen", 32'(found), 32'd1);
    check("redir first id_pc",   bus.id_pc,    32'h0000_0100);
    check("redir first instr",   bus.id_instr, instr_of(32'h0000_0100));
    tick();
    #1;
    check("redir second id_pc", bus.id_pc, 32'h0000_0104);
    tick();
    #1;
    check("redir third id_pc",  bus.id_pc, 32'h0000_0108);

    // ---- misaligned redirect: sticky error until reset ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    check("misalign before", 32'(misalign_err), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("misalign set",       32'(misalign_err),       32'd1);
    check("misalign req_valid", 32'(bus.imem_req_valid), 32'd0);
    repeat (3) tick();
    #1;
    check("misalign sticky",     32'(misalign_err),       32'd1);
    check("misalign req_valid2", 32'(bus.imem_req_valid), 32'd0);
    rst = 1'b1;
    tick();
    #1;
    check("rst clears misalign", 32'(misalign_err),  32'd0);
    check("rst pc",              bus.imem_req_addr,  32'h0);
    check("rst id_valid",        32'(bus.id_valid),  32'd0);
    rst = 1'b0;

    // ---- PC wrap at the top of the address space ----
    do_reset(1);
    fetch_en       = 1'b1;
    bus.id_ready   = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("wrap addr top",  bus.imem_req_addr,       32'hFFFF_FFFC);
    tick();
    #1;
    check("wrap addr zero", bus.imem_req_addr, 32'h0000_0000);
    tick();
    #1;
    check("wrap id_pc top",    bus.id_pc,       32'hFFFF_FFFC);
    check("wrap plus4 top",    bus.id_pc_plus4, 32'h0000_0000);
    tick();
    #1;
    check("wrap id_pc zero",   bus.id_pc,       32'h0000_0000);
    check("wrap plus4 zero",   bus.id_pc_plus4, 32'h0000_0004);

`ifdef MIPS_FETCH_PERF_EN
    // ---- performance counters: 5 pops, 2 redirects ----
    do_reset(1);
    #1;
    check("perf fetch reset", perf_fetch_cnt, 32'd0);
    check("perf flush reset", perf_flush_cnt, 32'd0);
    fetch_en     = 1'b1;
    bus.id_ready = 1'b0;
    repeat (8) tick();
    pops = 0;
    for (int k = 0; k < 40 && pops < 5; k++) begin
      if (bus.id_valid) begin
        bus.id_ready = 1'b1;
        pops++;
      end else begin
        bus.id_ready = 1'b0;
      end
      tick();
    end
    bus.id_ready   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("perf fetch count", perf_fetch_cnt, 32'd5);
    check("perf flush count", perf_flush_cnt, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
